// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Write-back strobe appears 33 edges after accept; flush aborts, async rst discards.
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [AW-1:0]    dst_reg,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             wb_en,
  output logic [AW-1:0]    wb_reg,
  output logic [WIDTH-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, next_state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [AW-1:0]    dst_q;
  logic [AW-1:0]    hold_reg;
  logic [WIDTH-1:0] hold_data;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] result;

  assign ready     = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = start && ready && !flush;
  assign last_step = (cnt == CW'(WIDTH));

  // hi:lo is the product for MUL and remainder:quotient for DIV/REM, so the
  // result is always hi for odd ops and lo for even ops.
  assign add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd_q};
  assign result  = op_q[0] ? hi_q : lo_q;

  assign wb_reg  = wb_en ? dst_q  : hold_reg;
  assign wb_data = wb_en ? result : hold_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    wb_en      = 1'b0;
    case (state)
      IDLE: if (accept) next_state = RUN;
      RUN: begin
        if (flush)          next_state = IDLE;
        else if (last_step) next_state = DONE;
      end
      DONE: begin
        wb_en      = !flush;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      dst_q     <= '0;
      cnt       <= '0;
      hold_reg  <= '0;
      hold_data <= '0;
    end else begin
      if (accept) begin
        op_q   <= op;
        opnd_q <= op[1] ? src_b : src_a;
        lo_q   <= op[1] ? src_a : src_b;
        hi_q   <= '0;
        dst_q  <= dst_reg;
        cnt    <= '0;
      end else if (state == RUN && !last_step) begin
        cnt <= cnt + 1'b1;
        if (!op_q[1]) begin
          hi_q <= add_sum[WIDTH:1];
          lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
          // A zero divisor never borrows: quotient fills with ones, remainder keeps the dividend.
          hi_q <= diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= shifted[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end
      if (wb_en) begin
        hold_reg  <= dst_q;
        hold_data <= result;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor checks result, index and latency.
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int AW = 4;

  typedef struct {
    logic [AW-1:0] r;
    logic [W-1:0]  d;
    int            e;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic [AW-1:0] dst_reg;
  logic          flush;
  logic          ready;
  logic          busy;
  logic          wb_en;
  logic [AW-1:0] wb_reg;
  logic [W-1:0]  wb_data;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  mul_div_unit #(.WIDTH(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst_reg(dst_reg), .flush(flush), .ready(ready), .busy(busy),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_en === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_wb actual reg=%0d data=%0h required no write-back", wb_reg, wb_data);
        end else begin
          e = sb.pop_front();
          if (wb_reg !== e.r || wb_data !== e.d || cyc != e.e) begin
            errors++;
            $display("FAIL wb actual reg=%0d data=%0h edge=%0d required reg=%0d data=%0h edge=%0d",
                     wb_reg, wb_data, cyc, e.r, e.d, e.e);
          end
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d, input logic expect_wb, input logic [W-1:0] res,
                       output int n);
    @(negedge clk);
    check("ready_before", ready, 1);
    op = o; src_a = a; src_b = b; dst_reg = d; start = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    if (expect_wb) sb.push_back('{d, res, n + 33});
    @(negedge clk);
    start = 1'b0;
    src_a = ~a; src_b = ~b; dst_reg = ~d;
    check("ready_fall", ready, 0);
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_done(input int n);
    while (cyc < n + 34) @(negedge clk);
    check("ready_back", ready, 1);
    check("busy_fall", busy, 0);
  endtask

  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [AW-1:0] d, input logic [W-1:0] res);
    int n;
    issue(o, a, b, d, 1'b1, res, n);
    wait_done(n);
    check("hold_data", wb_data, res);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0;
    src_a = '0; src_b = '0; dst_reg = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_reg", wb_reg, 0);
    check("rst_wb_data", wb_data, 0);
    rst = 1'b0;

    run(2'b00, 32'd7, 32'd6, 4'd3, 32'd42);
    run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'h0000_0001);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE);
    run(2'b10, 32'd100, 32'd7, 4'd4, 32'd14);
    run(2'b11, 32'd100, 32'd7, 4'd5, 32'd2);
    run(2'b10, 32'h4D2, 32'd0, 4'd6, 32'hFFFF_FFFF);
    run(2'b11, 32'h4D2, 32'd0, 4'd7, 32'h4D2);
    run(2'b01, 32'h8000_0000, 32'd4, 4'd8, 32'd2);

    // start held through RUN and DONE must not be taken
    issue(2'b00, 32'h12345, 32'h100, 4'd11, 1'b1, 32'h0123_4500, n);
    start = 1'b1; src_a = 32'd1; src_b = 32'd1; dst_reg = 4'd9;
    while (cyc < n + 33) @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("busy_start_reg", wb_reg, 11);

    // flush in RUN
    issue(2'b11, 32'd50, 32'd3, 4'd12, 1'b0, 32'd0, n);
    while (cyc < n + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_run_ready", ready, 1);
    check("flush_run_data", wb_data, 32'h0123_4500);
    check("flush_run_reg", wb_reg, 11);
    repeat (40) @(negedge clk);

    // flush during DONE
    issue(2'b10, 32'd50, 32'd3, 4'd13, 1'b0, 32'd0, n);
    while (cyc < n + 33) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    check("done_busy", busy, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done_ready", ready, 1);
    check("flush_done_data", wb_data, 32'h0123_4500);
    check("flush_done_reg", wb_reg, 11);

    // flush blocks a coincident start in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd3; dst_reg = 4'd14;
    @(negedge clk);
    check("flush_start_ready", ready, 1);
    check("flush_start_busy", busy, 0);
    start = 1'b0; flush = 1'b0;

    // async reset mid-RUN
    issue(2'b00, 32'd9, 32'd9, 4'd15, 1'b0, 32'd0, n);
    repeat (12) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready", ready, 1);
    check("arst_busy", busy, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_wb_reg", wb_reg, 0);
    check("arst_wb_data", wb_data, 0);
    @(negedge clk);
    rst = 1'b0;
    run(2'b00, 32'd5, 32'd9, 4'd0, 32'd45);

    repeat (40) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
